// File: rtl/window_gen_5x5_pkg.sv
// rtl/window_gen_5x5_pkg.sv - shared constants and helpers for the 5x5 window generator
package window_gen_5x5_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int WIN        = 5;
    localparam int LB_NUM     = WIN - 1;

    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int win_idx(input int r, input int c);
        return WIN * r + c + 1;
    endfunction

endpackage

// File: rtl/window_gen_5x5_line_buffer.sv
// rtl/window_gen_5x5_line_buffer.sv - one image line of storage, combinational read before same-edge write
module line_buffer #(
    parameter int DEPTH  = 640,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    // Contents are deliberately unreset; row gating hides stale data.
    logic [DATA_W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/window_gen_5x5.sv
// rtl/window_gen_5x5.sv - raster stream to 5x5 neighbourhood with inside-image valid gating
module window_gen_5x5
    import window_gen_5x5_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sof_in,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_in,
    output logic [DATA_W-1:0] pix1,  pix2,  pix3,  pix4,  pix5,
    output logic [DATA_W-1:0] pix6,  pix7,  pix8,  pix9,  pix10,
    output logic [DATA_W-1:0] pix11, pix12, pix13, pix14, pix15,
    output logic [DATA_W-1:0] pix16, pix17, pix18, pix19, pix20,
    output logic [DATA_W-1:0] pix21, pix22, pix23, pix24, pix25,
    output logic              win_valid,
    output logic              win_last
);

    localparam int COL_W = cnt_w(IMG_W);
    localparam int ROW_W = cnt_w(IMG_H);

    logic [COL_W-1:0] col_q, col_cur;
    logic [ROW_W-1:0] row_q, row_cur;
    logic             col_end, row_end;

    // sof_in relabels the current beat as (0,0) regardless of the counters.
    assign col_cur = sof_in ? '0 : col_q;
    assign row_cur = sof_in ? '0 : row_q;
    assign col_end = (col_cur == COL_W'(IMG_W - 1));
    assign row_end = (row_cur == ROW_W'(IMG_H - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (pix_valid) begin
            if (col_end) begin
                col_q <= '0;
                row_q <= row_end ? '0 : row_cur + ROW_W'(1);
            end else begin
                col_q <= col_cur + COL_W'(1);
                row_q <= row_cur;
            end
        end
    end

    logic [DATA_W-1:0] lb_wr [LB_NUM];
    logic [DATA_W-1:0] lb_rd [LB_NUM];
    logic [DATA_W-1:0] col_vec [WIN];

    assign lb_wr[0] = pix_in;

    for (genvar i = 0; i < LB_NUM; i++) begin : g_lb
        if (i > 0) begin : g_chain
            assign lb_wr[i] = lb_rd[i-1];
        end
        line_buffer #(
            .DEPTH  (IMG_W),
            .DATA_W (DATA_W),
            .ADDR_W (COL_W)
        ) u_lb (
            .clk   (clk),
            .we    (pix_valid),
            .addr  (col_cur),
            .wdata (lb_wr[i]),
            .rdata (lb_rd[i])
        );
    end

    // Oldest line (deepest buffer) lands in window row 0.
    for (genvar r = 0; r < LB_NUM; r++) begin : g_vec
        assign col_vec[r] = lb_rd[LB_NUM-1-r];
    end
    assign col_vec[WIN-1] = pix_in;

    logic [DATA_W-1:0] win [WIN][WIN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                    win[r][c] <= '0;
                end
            end
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else begin
            if (pix_valid) begin
                for (int r = 0; r < WIN; r++) begin
                    for (int c = 0; c < WIN - 1; c++) begin
                        win[r][c] <= win[r][c+1];
                    end
                    win[r][WIN-1] <= col_vec[r];
                end
            end
            win_valid <= pix_valid && (row_cur >= ROW_W'(WIN - 1)) && (col_cur >= COL_W'(WIN - 1));
            win_last  <= pix_valid && row_end && col_end;
        end
    end

    logic [DATA_W-1:0] win_flat [WIN*WIN];

    for (genvar r = 0; r < WIN; r++) begin : g_row
        for (genvar c = 0; c < WIN; c++) begin : g_col
            assign win_flat[win_idx(r, c) - 1] = win[r][c];
        end
    end

    assign pix1  = win_flat[0];
    assign pix2  = win_flat[1];
    assign pix3  = win_flat[2];
    assign pix4  = win_flat[3];
    assign pix5  = win_flat[4];
    assign pix6  = win_flat[5];
    assign pix7  = win_flat[6];
    assign pix8  = win_flat[7];
    assign pix9  = win_flat[8];
    assign pix10 = win_flat[9];
    assign pix11 = win_flat[10];
    assign pix12 = win_flat[11];
    assign pix13 = win_flat[12];
    assign pix14 = win_flat[13];
    assign pix15 = win_flat[14];
    assign pix16 = win_flat[15];
    assign pix17 = win_flat[16];
    assign pix18 = win_flat[17];
    assign pix19 = win_flat[18];
    assign pix20 = win_flat[19];
    assign pix21 = win_flat[20];
    assign pix22 = win_flat[21];
    assign pix23 = win_flat[22];
    assign pix24 = win_flat[23];
    assign pix25 = win_flat[24];

endmodule

// File: tb/tb_window_gen_5x5.sv
// tb/tb_window_gen_5x5.sv - self-checking bench for window_gen_5x5 against an image-array model
module tb_window_gen_5x5;

    localparam int W = 8;
    localparam int H = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sof_in = 1'b0;
    logic       pix_valid = 1'b0;
    logic [7:0] pix_in = 8'h00;
    logic [7:0] pix1, pix2, pix3, pix4, pix5, pix6, pix7, pix8, pix9, pix10;
    logic [7:0] pix11, pix12, pix13, pix14, pix15, pix16, pix17, pix18, pix19, pix20;
    logic [7:0] pix21, pix22, pix23, pix24, pix25;
    logic       win_valid, win_last;

    always #5 clk = ~clk;

    window_gen_5x5 #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .sof_in(sof_in), .pix_valid(pix_valid), .pix_in(pix_in),
        .pix1(pix1), .pix2(pix2), .pix3(pix3), .pix4(pix4), .pix5(pix5),
        .pix6(pix6), .pix7(pix7), .pix8(pix8), .pix9(pix9), .pix10(pix10),
        .pix11(pix11), .pix12(pix12), .pix13(pix13), .pix14(pix14), .pix15(pix15),
        .pix16(pix16), .pix17(pix17), .pix18(pix18), .pix19(pix19), .pix20(pix20),
        .pix21(pix21), .pix22(pix22), .pix23(pix23), .pix24(pix24), .pix25(pix25),
        .win_valid(win_valid), .win_last(win_last)
    );

    logic [25*8-1:0] dut_flat;
    assign dut_flat = {pix25, pix24, pix23, pix22, pix21, pix20, pix19, pix18, pix17, pix16,
                       pix15, pix14, pix13, pix12, pix11, pix10, pix9, pix8, pix7, pix6,
                       pix5, pix4, pix3, pix2, pix1};

    int errors = 0;
    int checks = 0;

    // Reference: image array written at each beat's raster position.
    logic [7:0] img [H][W];
    int         mr = 0, mc = 0;
    logic [7:0] cap [16][25];
    int         ncap = 0;

    typedef struct {
        int         idx;
        logic [7:0] p1, p5, p13, p21, p25;
    } tab_t;
    tab_t tab [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic s, input logic [7:0] p);
        logic       ev, el;
        logic [7:0] ew [25];
        int         r, c, bad;
        ev = 1'b0;
        el = 1'b0;
        pix_valid = v;
        sof_in    = s;
        pix_in    = p;
        if (!rst_n) begin
            mr = 0;
            mc = 0;
        end else if (v) begin
            r = s ? 0 : mr;
            c = s ? 0 : mc;
            img[r][c] = p;
            ev = (r >= 4) && (c >= 4);
            el = ev && (r == H - 1) && (c == W - 1);
            if (ev) begin
                for (int i = 0; i < 5; i++)
                    for (int j = 0; j < 5; j++)
                        ew[i*5+j] = img[r-4+i][c-4+j];
            end
            mr = r;
            mc = c + 1;
            if (mc == W) begin
                mc = 0;
                mr = (r + 1 == H) ? 0 : r + 1;
            end
        end
        @(posedge clk);
        #1;
        chk("win_valid", {31'b0, win_valid}, {31'b0, ev});
        chk("win_last", {31'b0, win_last}, {31'b0, el});
        if (!rst_n) chk("reset_window_zero", {31'b0, dut_flat == '0}, 32'd1);
        if (ev) begin
            bad = -1;
            for (int k = 24; k >= 0; k--)
                if (dut_flat[k*8 +: 8] !== ew[k]) bad = k;
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL window pix%0d actual=%0h expected=%0h at %0t",
                         bad + 1, dut_flat[bad*8 +: 8], ew[bad], $time);
            end
        end
        if (win_valid && ncap < 16) begin
            for (int k = 0; k < 25; k++) cap[ncap][k] = dut_flat[k*8 +: 8];
        end
        if (win_valid) ncap++;
    endtask

    // Drive a frame in raster order; stops before (stop_r, stop_c) when stop_r >= 0.
    task automatic frame(input int off, input bit gaps, input int stop_r, input int stop_c);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == stop_r && c == stop_c) return;
                while (gaps && $urandom_range(1) == 1) step(1'b0, 1'b0, 8'($urandom));
                step(1'b1, (r == 0 && c == 0), 8'(r * 16 + c + off));
            end
        end
    endtask

    task automatic check_tab(input string tag);
        for (int t = 0; t < 4; t++) begin
            chk({tag, "_p1"},  {24'b0, cap[tab[t].idx][0]},  {24'b0, tab[t].p1});
            chk({tag, "_p5"},  {24'b0, cap[tab[t].idx][4]},  {24'b0, tab[t].p5});
            chk({tag, "_p13"}, {24'b0, cap[tab[t].idx][12]}, {24'b0, tab[t].p13});
            chk({tag, "_p21"}, {24'b0, cap[tab[t].idx][20]}, {24'b0, tab[t].p21});
            chk({tag, "_p25"}, {24'b0, cap[tab[t].idx][24]}, {24'b0, tab[t].p25});
        end
    endtask

    initial begin
        tab[0] = '{0, 8'h00, 8'h04, 8'h22, 8'h40, 8'h44};
        tab[1] = '{3, 8'h03, 8'h07, 8'h25, 8'h43, 8'h47};
        tab[2] = '{4, 8'h10, 8'h14, 8'h32, 8'h50, 8'h54};
        tab[3] = '{7, 8'h13, 8'h17, 8'h35, 8'h53, 8'h57};

        #2;
        for (int i = 0; i < 4; i++) step(i[0], 1'b0, 8'hA5);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 8'h00);

        ncap = 0;
        frame(0, 1'b0, -1, -1);
        chk("cont_window_count", ncap, 8);
        check_tab("cont");
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00);

        ncap = 0;
        frame(0, 1'b1, -1, -1);
        chk("gap_window_count", ncap, 8);
        check_tab("gap");

        frame(8'h40, 1'b0, 2, 3);
        ncap = 0;
        frame(8'h80, 1'b0, -1, -1);
        chk("sof_window_count", ncap, 8);
        chk("sof_first_p1", {24'b0, cap[0][0]}, 32'h80);
        chk("sof_first_p25", {24'b0, cap[0][24]}, 32'hC4);

        frame(0, 1'b0, 4, 6);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, win_valid}, 32'd0);
        chk("async_rst_window", {31'b0, dut_flat == '0}, 32'd1);
        for (int i = 0; i < 3; i++) step(i[0], 1'b0, 8'h5A);
        rst_n = 1'b1;
        ncap = 0;
        frame(0, 1'b0, -1, -1);
        chk("rst_window_count", ncap, 8);
        check_tab("rst");
        step(1'b0, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
